// File: rtl/gpio_cfg_pkg.sv
// Shared types and constants for the GPIO pad-configuration serializer.
package gpio_cfg_pkg;

  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LOAD, DONE} gpio_cfg_state_t;

  localparam int GPIO_PAD_CTRL_BITS = 12;
  localparam logic [GPIO_PAD_CTRL_BITS-1:0] GPIO_CFG_DEFAULT = 12'hC00;

  function automatic int cfg_bits(input int pads, input int bits_per_pad);
    return pads * bits_per_pad;
  endfunction

endpackage

// File: rtl/gpio_cfg_serializer_if.sv
// Host-side handshake between the SoC config registers and the serializer.
interface gpio_cfg_serializer_if #(
  parameter int NUM_PADS      = 14,
  parameter int PAD_CTRL_BITS = 12
);
  logic [NUM_PADS*PAD_CTRL_BITS-1:0] cfg_data;
  logic                              xfer_start;
  logic                              xfer_busy;
  logic                              xfer_done;

  modport master (output cfg_data, xfer_start, input xfer_busy, xfer_done);
  modport slave  (input cfg_data, xfer_start, output xfer_busy, xfer_done);
endinterface

// File: rtl/gpio_cfg_clkdiv.sv
// Half-period divider: tick on every CLK_DIV-th enabled mclk, restarted by clr.
module gpio_cfg_clkdiv #(
  parameter int CLK_DIV = 2
)(
  input  logic mclk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int DW = $clog2(CLK_DIV + 1);

  logic [DW-1:0] cnt;

  assign tick = en && (cnt == DW'(CLK_DIV - 1));

  always_ff @(posedge mclk or posedge reset) begin
    if (reset)             cnt <= '0;
    else if (clr || tick)  cnt <= '0;
    else if (en)           cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/gpio_cfg_serializer.sv
// Serializes a parallel pad-config image onto the GPIO pad chain, then strobes load.
// Optional readback of the old chain contents: define GPIO_CFG_READBACK_EN.
module gpio_cfg_serializer
  import gpio_cfg_pkg::*;
#(
  parameter int NUM_PADS      = 14,
  parameter int PAD_CTRL_BITS = GPIO_PAD_CTRL_BITS,
  parameter int CLK_DIV       = 2
)(
  input  logic                  mclk,
  input  logic                  reset,
  gpio_cfg_serializer_if.slave  host,
  output logic                  serial_clock,
  output logic                  serial_load,
  output logic                  serial_data,
  output logic                  serial_resetn
`ifdef GPIO_CFG_READBACK_EN
  ,
  input  logic                  serial_data_ret,
  output logic [NUM_PADS*PAD_CTRL_BITS-1:0] rdbk_data
`endif
);
  localparam int T  = cfg_bits(NUM_PADS, PAD_CTRL_BITS);
  localparam int KW = $clog2(T + 1);

  gpio_cfg_state_t state, state_nxt;
  logic [T-1:0]    shreg, shreg_nxt;
  logic [KW-1:0]   k, k_nxt;
  logic            tick, div_en;

  assign div_en        = state inside {SHIFT_LO, SHIFT_HI, LOAD};
  assign serial_resetn = ~reset;

  gpio_cfg_clkdiv #(.CLK_DIV(CLK_DIV)) u_clkdiv (
    .mclk  (mclk),
    .reset (reset),
    .clr   (!div_en),
    .en    (div_en),
    .tick  (tick)
  );

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    k_nxt     = k;
    case (state)
      IDLE: if (host.xfer_start) begin
        state_nxt = SHIFT_LO;
        shreg_nxt = host.cfg_data;
        k_nxt     = '0;
      end
      SHIFT_LO: if (tick) state_nxt = SHIFT_HI;
      SHIFT_HI: if (tick) begin
        if (k == KW'(T - 1)) state_nxt = LOAD;
        else begin
          state_nxt = SHIFT_LO;
          k_nxt     = k + 1'b1;
          shreg_nxt = {shreg[T-2:0], 1'b0};
        end
      end
      LOAD:    if (tick) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from next-state so they change with the state itself.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      shreg          <= '0;
      k              <= '0;
      serial_clock   <= 1'b0;
      serial_load    <= 1'b0;
      serial_data    <= 1'b0;
      host.xfer_busy <= 1'b0;
      host.xfer_done <= 1'b0;
    end else begin
      state          <= state_nxt;
      shreg          <= shreg_nxt;
      k              <= k_nxt;
      serial_clock   <= (state_nxt == SHIFT_HI);
      serial_load    <= (state_nxt == LOAD);
      serial_data    <= (state_nxt inside {SHIFT_LO, SHIFT_HI}) && shreg_nxt[T-1];
      host.xfer_busy <= (state_nxt != IDLE);
      host.xfer_done <= (state_nxt == DONE);
    end
  end

`ifdef GPIO_CFG_READBACK_EN
  logic bit_done;
  assign bit_done = (state == SHIFT_HI) && tick;

  // Capture the chain's returning bit on the last mclk of each high phase.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset)         rdbk_data <= '0;
    else if (bit_done) rdbk_data <= {rdbk_data[T-2:0], serial_data_ret};
  end
`endif

endmodule

// File: tb/tb_gpio_cfg_serializer.sv
// Scoreboard bench for gpio_cfg_serializer: 2-pad/CLK_DIV=1 and 1-pad/CLK_DIV=3 instances.
module tb_gpio_cfg_serializer;
  localparam int TA = 24;
  localparam int TB = 12;

  logic mclk = 1'b0;
  logic reset;
  always #5 mclk = ~mclk;

  gpio_cfg_serializer_if #(.NUM_PADS(2), .PAD_CTRL_BITS(12)) ifa ();
  gpio_cfg_serializer_if #(.NUM_PADS(1), .PAD_CTRL_BITS(12)) ifb ();

  logic sclk_a, load_a, sdata_a, rstn_a;
  logic sclk_b, load_b, sdata_b, rstn_b;
`ifdef GPIO_CFG_READBACK_EN
  logic          ret_a, ret_b, chain_out;
  logic [TA-1:0] rdbk_a;
  logic [TB-1:0] rdbk_b;
  assign ret_a = chain_out;
  assign ret_b = 1'b0;
`endif

  gpio_cfg_serializer #(.NUM_PADS(2), .PAD_CTRL_BITS(12), .CLK_DIV(1)) dut_a (
    .mclk(mclk), .reset(reset), .host(ifa),
    .serial_clock(sclk_a), .serial_load(load_a), .serial_data(sdata_a), .serial_resetn(rstn_a)
`ifdef GPIO_CFG_READBACK_EN
    , .serial_data_ret(ret_a), .rdbk_data(rdbk_a)
`endif
  );

  gpio_cfg_serializer #(.NUM_PADS(1), .PAD_CTRL_BITS(12), .CLK_DIV(3)) dut_b (
    .mclk(mclk), .reset(reset), .host(ifb),
    .serial_clock(sclk_b), .serial_load(load_b), .serial_data(sdata_b), .serial_resetn(rstn_b)
`ifdef GPIO_CFG_READBACK_EN
    , .serial_data_ret(ret_b), .rdbk_data(rdbk_b)
`endif
  );

  // Pad chain model for instance A: shifts on serial_clock rise, last pad drives out on fall.
  logic          preload = 1'b0;
  logic [TA-1:0] preload_val = '0;
  logic [TA-1:0] chain;
  always @(posedge sclk_a or posedge preload)
    if (preload) chain <= preload_val;
    else         chain <= {chain[TA-2:0], sdata_a};
`ifdef GPIO_CFG_READBACK_EN
  always @(negedge sclk_a or posedge preload)
    if (preload) chain_out <= preload_val[TA-1];
    else         chain_out <= chain[TA-1];
`endif

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  typedef struct {
    logic [23:0] data;
    int          nbits;
    int          edges;
    int          half;
    int          busy;
    int          loads;
    int          dones;
  } xfer_exp_t;

  xfer_exp_t exp_q[$];

  logic [1:0] m_busy, m_done, m_sclk, m_load, m_sdata;
  assign m_busy  = {ifb.xfer_busy, ifa.xfer_busy};
  assign m_done  = {ifb.xfer_done, ifa.xfer_done};
  assign m_sclk  = {sclk_b, sclk_a};
  assign m_load  = {load_b, load_a};
  assign m_sdata = {sdata_b, sdata_a};

  // Monitor: samples on the falling mclk edge, checks against the front of exp_q.
  initial begin : mon
    logic [1:0] p_busy, p_sclk, p_load;
    int edges[2], bcnt[2], lcnt[2], dcnt[2], hi_run[2], lo_run[2];
    xfer_exp_t cur;
    p_busy = '0; p_sclk = '0; p_load = '0;
    for (int i = 0; i < 2; i++) begin
      edges[i] = 0; bcnt[i] = 0; lcnt[i] = 0; dcnt[i] = 0; hi_run[i] = 0; lo_run[i] = 0;
    end
    forever begin
      @(negedge mclk);
      for (int i = 0; i < 2; i++) begin
        if (m_busy[i] === 1'b1 && p_busy[i] !== 1'b1) begin
          check($sformatf("xfer_expected[%0d]", i), (exp_q.size() > 0) ? 1 : 0, 1);
          edges[i] = 0; bcnt[i] = 0; lcnt[i] = 0; dcnt[i] = 0; hi_run[i] = 0; lo_run[i] = 0;
        end
        if (m_busy[i] === 1'b1 && exp_q.size() > 0) begin
          cur = exp_q[0];
          bcnt[i]++;
          if (m_load[i]) lcnt[i]++;
          if (m_load[i] && !p_load[i])
            check($sformatf("edges_at_load[%0d]", i), edges[i], cur.nbits);
          if (m_done[i]) begin
            dcnt[i]++;
            check($sformatf("done_after_load[%0d]", i), p_load[i], 1);
          end
          if (m_sclk[i] && !p_sclk[i]) begin
            if (lo_run[i] > 0) check($sformatf("lo_phase[%0d]", i), lo_run[i], cur.half);
            lo_run[i] = 0;
            if (edges[i] < cur.nbits)
              check($sformatf("bit%0d[%0d]", edges[i], i), m_sdata[i], cur.data[cur.nbits-1-edges[i]]);
            else
              check($sformatf("extra_edge[%0d]", i), edges[i], cur.nbits - 1);
            edges[i]++;
          end
          if (m_sclk[i]) hi_run[i]++;
          else begin
            if (hi_run[i] > 0) check($sformatf("hi_phase[%0d]", i), hi_run[i], cur.half);
            hi_run[i] = 0;
            if (!m_load[i] && !m_done[i]) lo_run[i]++;
          end
        end
        if (m_busy[i] !== 1'b1 && p_busy[i] === 1'b1 && exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          check($sformatf("busy_cycles[%0d]", i), bcnt[i], cur.busy);
          check($sformatf("edge_count[%0d]", i), edges[i], cur.edges);
          check($sformatf("load_cycles[%0d]", i), lcnt[i], cur.loads);
          check($sformatf("done_pulses[%0d]", i), dcnt[i], cur.dones);
          hi_run[i] = 0; lo_run[i] = 0;
        end
        p_busy[i] = m_busy[i];
        p_sclk[i] = m_sclk[i];
        p_load[i] = m_load[i];
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  task automatic pulse_start(input int i);
    if (i == 0) ifa.xfer_start = 1'b1;
    else        ifb.xfer_start = 1'b1;
    cyc(1);
    ifa.xfer_start = 1'b0;
    ifb.xfer_start = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int n = 0;
    while (m_done[i] !== 1'b1 && n < budget) begin
      cyc(1);
      n++;
    end
    check($sformatf("done_seen[%0d]", i), m_done[i], 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.xfer_start = 1'b0; ifb.xfer_start = 1'b0;
    ifa.cfg_data   = '0;   ifb.cfg_data   = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    cyc(2);
    check("reset_outputs_a", {ifa.xfer_busy, ifa.xfer_done, sclk_a, load_a, sdata_a, rstn_a}, 0);
    check("reset_outputs_b", {ifb.xfer_busy, ifb.xfer_done, sclk_b, load_b, sdata_b, rstn_b}, 0);
    reset = 1'b0;
    cyc(1);
    check("resetn_released", {rstn_b, rstn_a}, 2'b11);
    check("idle_outputs_a", {ifa.xfer_busy, ifa.xfer_done, sclk_a, load_a, sdata_a}, 0);

    // Basic transfer; cfg_data is scrambled right after capture.
    ifa.cfg_data = 24'hABC123;
    exp_q.push_back('{data: 24'b1010_1011_1100_0001_0010_0011, nbits: 24, edges: 24,
                      half: 1, busy: 50, loads: 1, dones: 1});
    pulse_start(0);
    ifa.cfg_data = 24'h000000;
    wait_done(0, 100);
    check("pad1_cfg", chain[23:12], 12'hABC);
    check("pad0_cfg", chain[11:0], 12'h123);
    cyc(3);
    check("queue_drained_1", exp_q.size(), 0);

    // Start re-asserted in the 5th busy cycle and in the DONE cycle: both ignored.
    ifa.cfg_data = 24'hF0E1D2;
    exp_q.push_back('{data: 24'b1111_0000_1110_0001_1101_0010, nbits: 24, edges: 24,
                      half: 1, busy: 50, loads: 1, dones: 1});
    pulse_start(0);
    cyc(4);
    pulse_start(0);
    wait_done(0, 100);
    pulse_start(0);
    cyc(5);
    check("no_restart_busy", ifa.xfer_busy, 0);
    check("pad1_cfg_2", chain[23:12], 12'hF0E);
    check("pad0_cfg_2", chain[11:0], 12'h1D2);
    check("queue_drained_2", exp_q.size(), 0);

    // Slow divider, single pad.
    ifb.cfg_data = 12'h9E1;
    exp_q.push_back('{data: 24'b1001_1110_0001, nbits: 12, edges: 12,
                      half: 3, busy: 76, loads: 3, dones: 1});
    pulse_start(1);
    wait_done(1, 200);
    cyc(3);
    check("queue_drained_3", exp_q.size(), 0);
`ifdef GPIO_CFG_READBACK_EN
    check("rdbk_b_zero_ret", rdbk_b, 12'h000);
`endif

    // Reset during the high phase of bit 7 aborts without a done pulse.
    ifa.cfg_data = 24'hABC123;
    exp_q.push_back('{data: 24'b1010_1011_1100_0001_0010_0011, nbits: 24, edges: 7,
                      half: 1, busy: 15, loads: 0, dones: 0});
    pulse_start(0);
    cyc(15);
    check("bit7_sclk_high", sclk_a, 1);
    check("bit7_data", sdata_a, 1);
    reset = 1'b1;
    #1;
    check("abort_outputs", {ifa.xfer_busy, ifa.xfer_done, sclk_a, load_a, sdata_a, rstn_a}, 0);
    cyc(2);
    reset = 1'b0;
    cyc(2);
    check("queue_drained_abort", exp_q.size(), 0);

    ifa.cfg_data = 24'h36C95A;
    exp_q.push_back('{data: 24'b0011_0110_1100_1001_0101_1010, nbits: 24, edges: 24,
                      half: 1, busy: 50, loads: 1, dones: 1});
    pulse_start(0);
    wait_done(0, 100);
    check("pad1_cfg_post_abort", chain[23:12], 12'h36C);
    check("pad0_cfg_post_abort", chain[11:0], 12'h95A);
    cyc(3);

`ifdef GPIO_CFG_READBACK_EN
    preload_val = 24'h5A5F0F;
    preload = 1'b1;
    #1 preload = 1'b0;
    ifa.cfg_data = 24'hABC123;
    exp_q.push_back('{data: 24'b1010_1011_1100_0001_0010_0011, nbits: 24, edges: 24,
                      half: 1, busy: 50, loads: 1, dones: 1});
    pulse_start(0);
    wait_done(0, 100);
    check("rdbk_prev_chain", rdbk_a, 24'h5A5F0F);
    check("rdbk_new_chain", chain, 24'hABC123);
    cyc(3);
`endif

    check("queue_empty_end", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_cfg_serializer.md
Name: gpio_cfg_serializer

Overview:
- Drives the serial pad-configuration chain of the GPIO pad bank: serial_clock, serial_load and serial_data.
- Converts a parallel pad-configuration image into the bit stream that the per-pad control blocks shift in, then pulses the load strobe so every pad latches its configuration at once.
- Sits between the SoC configuration registers and the gpio_pads_left/right chains.

Parameters:
- NUM_PADS, 14: pads in the chain.
- PAD_CTRL_BITS, 12: configuration bits per pad.
- CLK_DIV, 2: mclk cycles per serial_clock half-period; legal range is 1 and above.

Ports:
- mclk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- cfg_data  input  NUM_PADS*PAD_CTRL_BITS  configuration image; pad i occupies [i*PAD_CTRL_BITS +: PAD_CTRL_BITS].
- xfer_start  input  1  single-cycle request to start a transfer.
- xfer_busy  output  1  high while a transfer is in progress.
- xfer_done  output  1  one-cycle pulse when a transfer completes.
- serial_clock  output  1  chain shift clock.
- serial_load  output  1  chain load strobe.
- serial_data  output  1  chain data, to serial_data_in of pad 0.
- serial_resetn  output  1  chain reset, equal to the inverse of reset.

Behaviour:
- Clocking and reset: one clock (mclk). Reset is asynchronous and active-high (reset).
- While reset is high, all outputs are 0 except serial_resetn, which is 0 because it is the inverse of reset. The state machine is forced to IDLE and the counters to 0.
- Reset asserted mid-transfer aborts the transfer immediately. No xfer_done pulse is produced.
- Derived constant: T = NUM_PADS*PAD_CTRL_BITS. The bit counter is $clog2(T+1) wide; the divider counter is $clog2(CLK_DIV+1) wide.
- State IDLE: all serial outputs are 0.
  - xfer_start sampled high: latch cfg_data into the shift register, clear the bit counter, go to SHIFT_LO.
- State SHIFT_LO: serial_clock=0; serial_data = cfg_data[T-1-k], where k is the bit count.
  - Stays CLK_DIV cycles, then goes to SHIFT_HI.
- State SHIFT_HI: serial_clock=1; serial_data is held stable.
  - Stays CLK_DIV cycles.
  - Then, if k==T-1, go to LOAD; otherwise increment k and go to SHIFT_LO.
- State LOAD: serial_clock=0, serial_load=1, serial_data=0.
  - Stays CLK_DIV cycles, then goes to DONE.
- State DONE: xfer_done=1 for exactly one cycle, then IDLE.
- Bit order: the MSB of the last pad is shifted first, the LSB of pad 0 last.
- Data changes only in SHIFT_LO, so serial_data is always stable across each serial_clock rising edge.
- xfer_busy is 1 in SHIFT_LO, SHIFT_HI, LOAD and DONE. It rises the cycle after xfer_start is sampled.
- Busy duration is T*2*CLK_DIV + CLK_DIV + 1 cycles.
- xfer_start while busy, including the DONE cycle, is ignored and not queued.
- cfg_data changes after capture do not affect the transfer in progress.
- All outputs are registered: no combinational path from any input to any output.

Optional Feature:
- Macro: GPIO_CFG_READBACK_EN.
- When defined, two ports are added:
  - serial_data_ret, input, 1 bit, driven from the serial_data_out of the last pad.
  - rdbk_data, output, T bits.
- On the last mclk of each SHIFT_HI, rdbk_data shifts left by 1 and serial_data_ret enters at bit 0.
  - After a complete transfer, rdbk_data holds the previous chain contents.
  - rdbk_data resets to 0 and is held, not cleared, at xfer_start.
- When not defined, neither port exists and no readback logic is instantiated.

Decomposition:
- Package gpio_cfg_pkg:
  - typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LOAD, DONE} gpio_cfg_state_t;
  - localparam GPIO_PAD_CTRL_BITS = 12;
  - localparam GPIO_CFG_DEFAULT = 12'hC00.
- One natural sub-module: gpio_cfg_clkdiv, the half-period divider producing a tick every CLK_DIV cycles. Its reset and enable are driven by the FSM.

Test Plan:
- Bench parameters: NUM_PADS=2, PAD_CTRL_BITS=12, CLK_DIV=1; cfg_data=24'hABC123; xfer_start pulsed.
  - Required: 24 serial_clock rising edges.
  - Bits sampled on those edges = 1010_1011_1100_0001_0010_0011 (MSB first).
  - serial_load high for 1 cycle after the last edge; xfer_done one cycle later.
  - xfer_busy high exactly 50 cycles.
- Same bench, pads connected as a chain model: after xfer_done, pad1 config = 12'hABC and pad0 = 12'h123.
- CLK_DIV=3, 1 pad: serial_clock high and low phases each 3 cycles; busy = 12*6+3+1 = 76 cycles.
- xfer_start re-asserted in the 5th busy cycle, and again in the DONE cycle: no restart, exactly one xfer_done.
- reset asserted in SHIFT_HI of bit 7: outputs 0 asynchronously and no xfer_done. A new xfer_start after release gives a clean full 24-bit transfer.
- GPIO_CFG_READBACK_EN defined, chain preloaded with 24'h5A5F0F: rdbk_data == 24'h5A5F0F after xfer_done, and the new config 24'hABC123 is loaded.
